lsu_agu_exec: RTL and testbench
===============================

Name: lsu_agu_exec

Overview:
- Execute-stage consumer of the decode info bus for memory ops (type field 3'b010: lb/lh/lw/lbu/lhu/sb/sh/sw).
- Computes the effective address as rs1 + imm and runs a request/grant/response transaction on the data-memory port.
- Aligns and extends load data, then returns a writeback to the regfile and holds a stall to hazard control while a transaction is in flight.

Parameters:
- DECODE_INFO_BUS_WIDTH, 14, width of the decode info bus: [13:11] type, [10:0] op one-hot.
- ADDR_WIDTH, 32, data-memory address width.

Ports:
- clk_sys  in  1  system clock.
- rst_sys  in  1  reset, asynchronous, active-low.
- i_decode_info_bus  in  DECODE_INFO_BUS_WIDTH  from ID/EX register; bits 0..7 = lb,lh,lw,lbu,lhu,sb,sh,sw when [13:11]==3'b010.
- i_rs1data_e  in  32  base register.
- i_rs2data_e  in  32  store data.
- i_imm_e  in  32  sign-extended offset.
- i_rdidx_e  in  5  load destination.
- i_flush  in  1  kill the in-flight op.
- o_stall  out  1  to hazard control: hold ID/EX and earlier stages.
- o_mem_req  out  1  request valid.
- o_mem_we  out  1  1 = store.
- o_mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_wstrb  out  4  byte enables (0 for loads).
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_rvalid  in  1  response; read data or write ack.
- i_mem_rdata  in  32  read data.
- o_wb_valid  out  1  one-cycle load writeback pulse.
- o_wb_rdidx  out  5  writeback index.
- o_wb_data  out  32  aligned/extended load data.
- o_misalign  out  1  one-cycle pulse: misaligned access, no bus traffic.

Behaviour:
- Reset (rst_sys low, async): state IDLE; all outputs 0; latched address/op/rdidx cleared.
- mem_op = (type==3'b010) & |bus[7:0]. Effective address = rs1 + imm, mod 2^32, computed in IDLE only.
- Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - mem_op & ~i_flush & misaligned -> o_misalign=1 for one cycle; stay IDLE; o_stall=0.
  - mem_op & ~i_flush & aligned -> latch addr, op, rdidx, wdata, wstrb; go REQ. o_stall=1 combinationally in this same cycle.
  - i_flush -> op dropped, no action.
- REQ:
  - o_mem_req=1; addr/we/wdata/wstrb are driven from latches and held stable until grant.
  - i_mem_gnt -> RSP.
  - i_flush before grant -> drop req next cycle; go IDLE; no writeback.
- RSP:
  - o_mem_req=0. Wait for i_mem_rvalid.
  - On rvalid -> IDLE; for loads, o_wb_valid=1 with data registered from rdata (1 cycle after rvalid).
  - i_flush during RSP -> set kill flag; still wait for rvalid; suppress o_wb_valid.
- Grant and rvalid in the same cycle: rvalid is ignored while in REQ. The memory port guarantees rvalid no earlier than the cycle after gnt.
- o_stall:
  - high from accept through the cycle rvalid is seen;
  - low in the o_wb_valid cycle, so the next op can be accepted in that cycle;
  - never high in IDLE without a new mem_op.
- Store lanes: sb -> wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0]; sh -> wdata={2{rs2[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}; sw -> wstrb=4'hF.
- Load extract: shifted = rdata >> {addr[1:0],3'b000}. lb/lh sign-extend, lbu/lhu zero-extend; lw passes through.
- Non-mem types (ALU/BJP/CSR) are ignored entirely.
- Minimum latency, 0-wait memory: accept T0, gnt T1, rvalid T2, wb_valid T3.

Decomposition:
- Shared package core_decode_pkg holds:
  - type codes 3'b000/001/010/011;
  - agu bit indices LB=0..SW=7;
  - FSM state encoding.
- Sub-module lsu_align (combinational) holds store lane/strobe generation and load extract/extend. The FSM and latches stay in lsu_agu_exec.

Test Plan:
- lw, rs1=0x1000, imm=0x10, 0-wait, rdata=0xDEADBEEF -> req addr=0x1010, wstrb=0; wb_valid at T3, data=0xDEADBEEF; stall high T0..T2.
- lb, addr=0x1003, rdata=0x80FF_0000 -> wb_data=0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh, addr=0x2002, rs2=0x1234ABCD -> wdata=0xABCDABCD, wstrb=4'b1100, we=1; no wb_valid after rvalid.
- lw at 0x1001 -> o_misalign pulse 1 cycle, o_mem_req never asserted, stall 0.
- gnt held low 3 cycles -> req/addr stable throughout; flush in 2nd cycle -> req drops, IDLE, no wb.
- flush during RSP for lw, rvalid 2 cycles later -> no wb_valid; stall released on rvalid; rst_sys low mid-RSP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/core_decode_pkg.sv
// Shared decode definitions: instruction type codes, memory-op one-hot
// bit positions on the decode info bus, and the LSU FSM state encoding.
package core_decode_pkg;

  // Instruction type field [13:11] of the decode info bus
  localparam logic [2:0] TYPE_ALU = 3'b000;
  localparam logic [2:0] TYPE_BJP = 3'b001;
  localparam logic [2:0] TYPE_MEM = 3'b010;
  localparam logic [2:0] TYPE_CSR = 3'b011;

  // One-hot op positions for memory ops (bus[7:0])
  localparam int unsigned AGU_LB  = 0;
  localparam int unsigned AGU_LH  = 1;
  localparam int unsigned AGU_LW  = 2;
  localparam int unsigned AGU_LBU = 3;
  localparam int unsigned AGU_LHU = 4;
  localparam int unsigned AGU_SB  = 5;
  localparam int unsigned AGU_SH  = 6;
  localparam int unsigned AGU_SW  = 7;

  // Load/store transaction state
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2
  } lsu_state_e;

  // Halfword accesses need bit 0 clear, word accesses need both low bits clear
  function automatic logic is_misaligned(input logic half, input logic word,
                                         input logic [1:0] off);
    return (half & off[0]) | (word & (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering for the LSU: store byte-lane replication and
// strobe generation, and load byte/halfword extraction with extension.
module lsu_align
  import core_decode_pkg::*;
(
  input  logic        st_sb_i,
  input  logic        st_sh_i,
  input  logic        st_sw_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [4:0]  ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  // Store: replicate the narrow datum across all lanes, enable only its lanes
  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = '0;
    if (st_sb_i) begin
      st_wdata_o = {4{st_data_i[7:0]}};
      st_wstrb_o = 4'b0001 << st_off_i;
    end else if (st_sh_i) begin
      st_wdata_o = {2{st_data_i[15:0]}};
      st_wstrb_o = 4'b0011 << {st_off_i[1], 1'b0};
    end else if (st_sw_i) begin
      st_wstrb_o = 4'hF;
    end
  end

  // Load: bring the addressed lane down to bit 0, then extend per op
  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_data_o  = ld_rdata_i;
    if (ld_op_i[AGU_LB]) begin
      ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
    end else if (ld_op_i[AGU_LH]) begin
      ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
    end else if (ld_op_i[AGU_LBU]) begin
      ld_data_o = {24'd0, ld_shifted[7:0]};
    end else if (ld_op_i[AGU_LHU]) begin
      ld_data_o = {16'd0, ld_shifted[15:0]};
    end else if (ld_op_i[AGU_LW]) begin
      ld_data_o = ld_rdata_i;
    end
  end

endmodule

// File: rtl/lsu_agu_exec.sv
// Execute-stage load/store unit: computes rs1+imm, runs one req/gnt/rsp
// transaction on the data-memory port, and writes back aligned load data.
module lsu_agu_exec
  import core_decode_pkg::*;
#(
  parameter int unsigned DECODE_INFO_BUS_WIDTH = 14,
  parameter int unsigned ADDR_WIDTH            = 32
) (
  input  logic                             clk_sys,
  input  logic                             rst_sys,
  input  logic [DECODE_INFO_BUS_WIDTH-1:0] i_decode_info_bus,
  input  logic [31:0]                      i_rs1data_e,
  input  logic [31:0]                      i_rs2data_e,
  input  logic [31:0]                      i_imm_e,
  input  logic [4:0]                       i_rdidx_e,
  input  logic                             i_flush,
  output logic                             o_stall,
  output logic                             o_mem_req,
  output logic                             o_mem_we,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  output logic [31:0]                      o_mem_wdata,
  output logic [3:0]                       o_mem_wstrb,
  input  logic                             i_mem_gnt,
  input  logic                             i_mem_rvalid,
  input  logic [31:0]                      i_mem_rdata,
  output logic                             o_wb_valid,
  output logic [4:0]                       o_wb_rdidx,
  output logic [31:0]                      o_wb_data,
  output logic                             o_misalign
);

  lsu_state_e  state_q, state_d;
  logic        kill_q, kill_d;
  logic        wb_valid_d;
  logic        accept, misalign_pulse;

  logic [31:0] addr_q;
  logic [4:0]  ld_op_q;
  logic        we_q;
  logic [4:0]  rdidx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        wb_valid_q;
  logic [4:0]  wb_rdidx_q;
  logic [31:0] wb_data_q;

  logic [2:0]  dec_type;
  logic [7:0]  dec_op;
  logic        mem_op;
  logic [31:0] eff_addr;
  logic        is_half, is_word, misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_data;
  logic        unused_dec;

  assign dec_type   = i_decode_info_bus[DECODE_INFO_BUS_WIDTH-1 -: 3];
  assign dec_op     = i_decode_info_bus[7:0];
  assign unused_dec = ^i_decode_info_bus[DECODE_INFO_BUS_WIDTH-4:8];
  assign mem_op     = (dec_type == TYPE_MEM) & (|dec_op);
  assign eff_addr   = i_rs1data_e + i_imm_e;
  assign is_half    = dec_op[AGU_LH] | dec_op[AGU_LHU] | dec_op[AGU_SH];
  assign is_word    = dec_op[AGU_LW] | dec_op[AGU_SW];
  assign misaligned = is_misaligned(is_half, is_word, eff_addr[1:0]);

  // Store steering uses the live decode inputs; load steering uses the latched op
  lsu_align u_align (
    .st_sb_i    (dec_op[AGU_SB]),
    .st_sh_i    (dec_op[AGU_SH]),
    .st_sw_i    (dec_op[AGU_SW]),
    .st_off_i   (eff_addr[1:0]),
    .st_data_i  (i_rs2data_e),
    .st_wdata_o (st_wdata),
    .st_wstrb_o (st_wstrb),
    .ld_op_i    (ld_op_q),
    .ld_off_i   (addr_q[1:0]),
    .ld_rdata_i (i_mem_rdata),
    .ld_data_o  (ld_data)
  );

  // Next-state, accept/misalign decisions and writeback qualification
  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    wb_valid_d     = 1'b0;
    accept         = 1'b0;
    misalign_pulse = 1'b0;
    unique case (state_q)
      LSU_IDLE: begin
        if (mem_op && !i_flush) begin
          if (misaligned) begin
            misalign_pulse = 1'b1;
          end else begin
            accept  = 1'b1;
            kill_d  = 1'b0;
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        // A flush coinciding with grant cannot retract the bus transfer,
        // so it is carried into RSP as a kill instead.
        if (i_mem_gnt) begin
          state_d = LSU_RSP;
          kill_d  = i_flush;
        end else if (i_flush) begin
          state_d = LSU_IDLE;
        end
      end
      LSU_RSP: begin
        if (i_mem_rvalid) begin
          state_d    = LSU_IDLE;
          wb_valid_d = (|ld_op_q) & ~kill_q & ~i_flush;
          kill_d     = 1'b0;
        end else if (i_flush) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // FSM state and kill flag
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q <= LSU_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Request latches, captured on accept and held until the next accept
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      addr_q  <= '0;
      ld_op_q <= '0;
      we_q    <= 1'b0;
      rdidx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= eff_addr;
      ld_op_q <= dec_op[AGU_LHU:AGU_LB];
      we_q    <= |dec_op[AGU_SW:AGU_SB];
      rdidx_q <= i_rdidx_e;
      wdata_q <= st_wdata;
      wstrb_q <= st_wstrb;
    end
  end

  // Load writeback register, one cycle behind rvalid
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      wb_valid_q <= 1'b0;
      wb_rdidx_q <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      if (wb_valid_d) begin
        wb_rdidx_q <= rdidx_q;
        wb_data_q  <= ld_data;
      end
    end
  end

  // Combinational outputs are gated by reset so the port reads all-zero in reset
  assign o_stall     = rst_sys & (accept | (state_q != LSU_IDLE));
  assign o_misalign  = rst_sys & misalign_pulse;
  assign o_mem_req   = (state_q == LSU_REQ);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_wdata = wdata_q;
  assign o_mem_wstrb = wstrb_q;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_rdidx  = wb_rdidx_q;
  assign o_wb_data   = wb_data_q;

endmodule

// File: tb/tb_lsu_agu_exec.sv
// Self-checking bench for lsu_agu_exec: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_lsu_agu_exec;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic [13:0] dec_bus;
  logic [31:0] rs1, rs2, imm;
  logic [4:0]  rdidx;
  logic        flush;
  logic        stall, mem_req, mem_we, mem_gnt, mem_rvalid, wb_valid, misalign;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_rdidx;

  int n_vec = 0;
  int n_err = 0;

  lsu_agu_exec #(.DECODE_INFO_BUS_WIDTH(14), .ADDR_WIDTH(32)) dut (
    .clk_sys          (clk_sys),
    .rst_sys          (rst_sys),
    .i_decode_info_bus(dec_bus),
    .i_rs1data_e      (rs1),
    .i_rs2data_e      (rs2),
    .i_imm_e          (imm),
    .i_rdidx_e        (rdidx),
    .i_flush          (flush),
    .o_stall          (stall),
    .o_mem_req        (mem_req),
    .o_mem_we         (mem_we),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .o_mem_wstrb      (mem_wstrb),
    .i_mem_gnt        (mem_gnt),
    .i_mem_rvalid     (mem_rvalid),
    .i_mem_rdata      (mem_rdata),
    .o_wb_valid       (wb_valid),
    .o_wb_rdidx       (wb_rdidx),
    .o_wb_data        (wb_data),
    .o_misalign       (misalign)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [13:0] mk_bus(input int op);
    logic [13:0] b;
    b = '0;
    b[13:11] = 3'b010;
    b[op] = 1'b1;
    return b;
  endfunction

  // One memory op: 0 lb,1 lh,2 lw,3 lbu,4 lhu,5 sb,6 sh,7 sw.
  // flush_req: REQ-cycle index (< gdly) to flush at, or -1.
  // flush_rsp: RSP wait-cycle index (< rdly) to flush at, or -1.
  task automatic do_op(input int op, input logic [31:0] a_rs1, input logic [31:0] a_imm,
                       input logic [31:0] a_rs2, input logic [4:0] a_rd,
                       input logic [31:0] rdata, input int gdly, input int rdly,
                       input int flush_req, input int flush_rsp);
    logic [31:0] ea, exp_wd, exp_wb, b8, h16;
    logic [3:0]  exp_ws;
    int          off;
    bit          is_load, mis;
    ea      = a_rs1 + a_imm;
    off     = int'(ea[1:0]);
    is_load = (op < 5);
    mis     = ((op == 1 || op == 4 || op == 6) && ea[0]) ||
              ((op == 2 || op == 7) && off != 0);
    b8      = (rdata >> (8 * off)) & 32'hFF;
    h16     = (rdata >> (8 * off)) & 32'hFFFF;
    case (op)
      0: exp_wb = (b8 >= 32'd128) ? (b8 | 32'hFFFF_FF00) : b8;
      1: exp_wb = (h16 >= 32'h8000) ? (h16 | 32'hFFFF_0000) : h16;
      3: exp_wb = b8;
      4: exp_wb = h16;
      default: exp_wb = rdata;
    endcase
    exp_wd = 32'h0; exp_ws = 4'h0;
    case (op)
      5: begin exp_wd = (a_rs2 & 32'hFF) * 32'h0101_0101;   exp_ws = 4'(1 << off); end
      6: begin exp_wd = (a_rs2 & 32'hFFFF) * 32'h0001_0001; exp_ws = 4'(3 << off); end
      7: begin exp_wd = a_rs2;                               exp_ws = 4'hF;         end
      default: ;
    endcase

    dec_bus = mk_bus(op); rs1 = a_rs1; imm = a_imm; rs2 = a_rs2; rdidx = a_rd;
    flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    check("stall_accept", 32'(stall), 32'(!mis));
    check("misalign", 32'(misalign), 32'(mis));
    check("req_in_idle", 32'(mem_req), 32'h0);
    step();
    dec_bus = '0;
    #1;
    if (mis) begin
      check("misalign_drop", 32'(misalign), 32'h0);
      check("mis_stall", 32'(stall), 32'h0);
      check("mis_req", 32'(mem_req), 32'h0);
      return;
    end
    for (int i = 0; i <= gdly; i++) begin
      check("req", 32'(mem_req), 32'h1);
      check("addr", mem_addr, ea & 32'hFFFF_FFFC);
      check("we", 32'(mem_we), 32'(!is_load));
      check("wstrb", 32'(mem_wstrb), 32'(exp_ws));
      if (!is_load) check("wdata", mem_wdata, exp_wd);
      check("stall_req", 32'(stall), 32'h1);
      if (i == 0) check("wb_pulse_end", 32'(wb_valid), 32'h0);
      if (i == flush_req) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("req_drop_flush", 32'(mem_req), 32'h0);
        check("stall_after_flush", 32'(stall), 32'h0);
        repeat (3) begin
          step();
          check("no_wb_flush_req", 32'(wb_valid), 32'h0);
          check("no_req_flush_req", 32'(mem_req), 32'h0);
        end
        return;
      end
      if (i == gdly) mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
    end
    for (int j = 0; j <= rdly; j++) begin
      check("req_rsp", 32'(mem_req), 32'h0);
      check("stall_rsp", 32'(stall), 32'h1);
      check("wb_in_rsp", 32'(wb_valid), 32'h0);
      if (j == flush_rsp) flush = 1'b1;
      if (j == rdly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
      end
      step();
      flush = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    check("wb_valid", 32'(wb_valid), 32'(is_load && flush_rsp < 0));
    if (is_load && flush_rsp < 0) begin
      check("wb_data", wb_data, exp_wb);
      check("wb_rdidx", 32'(wb_rdidx), 32'(a_rd));
    end
    check("stall_wb", 32'(stall), 32'h0);
    check("req_wb", 32'(mem_req), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int op, gd, rd, fr, fs;
    logic [31:0] r1, im;
    rst_sys = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    dec_bus = mk_bus(2); rs1 = 32'h1000; imm = 32'h0; rs2 = '0; rdidx = 5'd1;
    #12;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wb", 32'(wb_valid), 32'h0);
    check("rst_mis", 32'(misalign), 32'h0);
    dec_bus = '0;
    rst_sys = 1'b1;
    step();

    do_op(2, 32'h1000, 32'h10, 32'h0, 5'd3, 32'hDEAD_BEEF, 0, 0, -1, -1);
    step();
    do_op(0, 32'h1000, 32'h3, 32'h0, 5'd4, 32'h80FF_0000, 0, 0, -1, -1);
    do_op(3, 32'h1000, 32'h3, 32'h0, 5'd5, 32'h80FF_0000, 0, 0, -1, -1);
    do_op(6, 32'h2000, 32'h2, 32'h1234_ABCD, 5'd6, 32'h0, 0, 0, -1, -1);
    step(); check("no_wb_store", 32'(wb_valid), 32'h0);
    do_op(2, 32'h1000, 32'h1, 32'h0, 5'd7, 32'h0, 0, 0, -1, -1);
    do_op(2, 32'h3000, 32'h8, 32'h0, 5'd8, 32'h1111_2222, 3, 0, 1, -1);
    do_op(2, 32'h3000, 32'hC, 32'h0, 5'd9, 32'h3333_4444, 0, 2, -1, 0);
    step(); check("no_wb_killed", 32'(wb_valid), 32'h0);

    // Non-memory type with op bits set must be ignored
    dec_bus = {3'b000, 3'b000, 8'hFF}; rs1 = 32'h1001; imm = 32'h0;
    #1;
    check("alu_stall", 32'(stall), 32'h0);
    check("alu_mis", 32'(misalign), 32'h0);
    step(); check("alu_req", 32'(mem_req), 32'h0);
    // Flush in IDLE drops the op
    dec_bus = mk_bus(2); rs1 = 32'h4000; flush = 1'b1;
    #1;
    check("flush_idle_stall", 32'(stall), 32'h0);
    step(); flush = 1'b0; dec_bus = '0;
    check("flush_idle_req", 32'(mem_req), 32'h0);

    // Asynchronous reset in the middle of RSP
    dec_bus = mk_bus(7); rs1 = 32'h5000; imm = 32'h4; rs2 = 32'hCAFE_F00D;
    step(); dec_bus = '0; mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0;
    check("pre_rst_stall", 32'(stall), 32'h1);
    #2 rst_sys = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'h0);
    check("arst_req", 32'(mem_req), 32'h0);
    check("arst_we", 32'(mem_we), 32'h0);
    check("arst_addr", mem_addr, 32'h0);
    check("arst_wdata", mem_wdata, 32'h0);
    check("arst_wstrb", 32'(mem_wstrb), 32'h0);
    check("arst_wb", 32'(wb_valid), 32'h0);
    step(); rst_sys = 1'b1; step();

    for (int n = 0; n < 250; n++) begin
      op = int'($urandom_range(0, 7));
      r1 = $urandom;
      im = 32'($urandom_range(0, 63)) - 32'd32;
      gd = int'($urandom_range(0, 3));
      rd = int'($urandom_range(0, 3));
      fr = (gd > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, gd - 1)) : -1;
      fs = (rd > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, rd - 1)) : -1;
      do_op(op, r1, im, $urandom, 5'($urandom), $urandom, gd, rd, fr, fs);
      if ($urandom_range(0, 1) == 0) begin
        step();
        check("idle_wb", 32'(wb_valid), 32'h0);
        check("idle_stall", 32'(stall), 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
